// File: rtl/gnr_pkg.sv
// Shared constants and elaboration helpers for the GNR node blocks.
package gnr_pkg;

    localparam logic MODE_FLOYD = 1'b0;
    localparam logic MODE_LOCK  = 1'b1;

    localparam int RATIO_MIN = 32'sd1;
    localparam int RATIO_MAX = 32'sd255;

    function automatic bit ratio_ok(input int ratio);
        return (ratio >= RATIO_MIN) && (ratio <= RATIO_MAX);
    endfunction

    // Phase register width; at least one bit so RATIO = 1 still has a legal vector.
    function automatic int clog2(input int value);
        int w;
        w = 32'sd1;
        while ((32'sd1 << w) < value) begin
            w = w + 32'sd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/gnr_phase_div.sv
// Strobe divider: fires on every RATIO-th enable in Floyd mode, on every enable in lock mode.
module gnr_phase_div
    import gnr_pkg::*;
#(
    parameter int RATIO = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    input  logic lock,
    output logic fire
);

    localparam int            PW      = clog2(RATIO);
    localparam logic [PW-1:0] PH_LAST = PW'(RATIO - 1);

    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;
    logic          at_last;

    // Next phase and fire decision; load wins over any strobe.
    always_comb begin
        phase_d = phase_q;
        at_last = (phase_q == PH_LAST);
        fire    = 1'b0;
        if (load) begin
            phase_d = PH_LAST;
        end else if (en && (lock == MODE_LOCK)) begin
            fire    = 1'b1;
        end else if (en) begin
            fire = at_last;
            if (at_last) begin
                phase_d = '0;
            end else begin
                phase_d = phase_q + PW'(1);
            end
        end else begin
            phase_d = phase_q;
        end
    end

    // Phase register; asynchronous reset leaves phase at 0 so the first strobe only steps it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/gnr_node_floyd.sv
// GNR node with slow/fast state copies for Floyd cycle detection, step counter and equality flag.
module gnr_node_floyd
    import gnr_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int RATIO = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reset_nos,
    input  logic             start_s0,
    input  logic             start_s1,
    input  logic             mode_lock,
    input  logic [WIDTH-1:0] init_state,
    input  logic [WIDTH-1:0] p_s0,
    input  logic [WIDTH-1:0] p_s1,
    output logic [WIDTH-1:0] s0,
    output logic [WIDTH-1:0] s1,
    output logic [WIDTH-1:0] atf_s0,
    output logic [WIDTH-1:0] atf_s1,
    output logic             eq,
    output logic             s1_chg,
    output logic [CNT_W-1:0] steps,
    output logic             steps_sat
);

    if (!ratio_ok(RATIO)) begin : g_bad_ratio
        $error("gnr_node_floyd: RATIO must be within 1..255");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("gnr_node_floyd: WIDTH must be at least 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("gnr_node_floyd: CNT_W must be at least 1");
    end

    localparam logic [CNT_W-1:0] STEPS_MAX = '1;

    logic [WIDTH-1:0] s0_q, s0_d;
    logic [WIDTH-1:0] s1_q, s1_d;
    logic             eq_q, eq_d;
    logic             s1_chg_q, s1_chg_d;
    logic [CNT_W-1:0] steps_q, steps_d;
    logic             steps_sat_q, steps_sat_d;
    logic             fire_s0;

    gnr_phase_div #(
        .RATIO (RATIO)
    ) u_phase (
        .clk  (clk),
        .rst  (rst),
        .load (reset_nos),
        .en   (start_s0),
        .lock (mode_lock),
        .fire (fire_s0)
    );

    // Next-state for both copies, counter and flags; eq and steps_sat follow the next values.
    always_comb begin
        s0_d     = s0_q;
        s1_d     = s1_q;
        steps_d  = steps_q;
        s1_chg_d = 1'b0;
        if (reset_nos) begin
            s0_d    = init_state;
            s1_d    = init_state;
            steps_d = '0;
        end else begin
            if (fire_s0) begin
                s0_d = p_s0;
            end else begin
                s0_d = s0_q;
            end
            if (start_s1) begin
                s1_d     = p_s1;
                s1_chg_d = (p_s1 != s1_q);
                if (steps_q != STEPS_MAX) begin
                    steps_d = steps_q + CNT_W'(1);
                end else begin
                    steps_d = steps_q;
                end
            end else begin
                s1_d = s1_q;
            end
        end
        eq_d        = (s0_d == s1_d);
        steps_sat_d = (steps_d == STEPS_MAX);
    end

    // State registers; reset leaves both copies equal, hence eq = 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_q        <= '0;
            s1_q        <= '0;
            eq_q        <= 1'b1;
            s1_chg_q    <= 1'b0;
            steps_q     <= '0;
            steps_sat_q <= 1'b0;
        end else begin
            s0_q        <= s0_d;
            s1_q        <= s1_d;
            eq_q        <= eq_d;
            s1_chg_q    <= s1_chg_d;
            steps_q     <= steps_d;
            steps_sat_q <= steps_sat_d;
        end
    end

    assign s0        = s0_q;
    assign s1        = s1_q;
    assign atf_s0    = s0_q;
    assign atf_s1    = s1_q;
    assign eq        = eq_q;
    assign s1_chg    = s1_chg_q;
    assign steps     = steps_q;
    assign steps_sat = steps_sat_q;

endmodule

// File: tb/tb_gnr_node_floyd.sv
// Directed bench: dut_a (WIDTH=1, RATIO=2, CNT_W=16) and dut_b (WIDTH=3, RATIO=3, CNT_W=4).
module tb_gnr_node_floyd;

    logic clk;
    logic rst;

    logic       a_reset_nos, a_start_s0, a_start_s1, a_mode_lock;
    logic [0:0] a_init, a_p_s0, a_p_s1;
    logic [0:0] a_s0, a_s1, a_atf_s0, a_atf_s1;
    logic       a_eq, a_s1_chg, a_steps_sat;
    logic [15:0] a_steps;

    logic       b_reset_nos, b_start_s0, b_start_s1, b_mode_lock;
    logic [2:0] b_init, b_p_s0, b_p_s1;
    logic [2:0] b_s0, b_s1, b_atf_s0, b_atf_s1;
    logic       b_eq, b_s1_chg, b_steps_sat;
    logic [3:0] b_steps;

    int checks;
    int errors;

    gnr_node_floyd #(.WIDTH(1), .RATIO(2), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .reset_nos(a_reset_nos), .start_s0(a_start_s0),
        .start_s1(a_start_s1), .mode_lock(a_mode_lock), .init_state(a_init),
        .p_s0(a_p_s0), .p_s1(a_p_s1), .s0(a_s0), .s1(a_s1), .atf_s0(a_atf_s0),
        .atf_s1(a_atf_s1), .eq(a_eq), .s1_chg(a_s1_chg), .steps(a_steps),
        .steps_sat(a_steps_sat)
    );

    gnr_node_floyd #(.WIDTH(3), .RATIO(3), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .reset_nos(b_reset_nos), .start_s0(b_start_s0),
        .start_s1(b_start_s1), .mode_lock(b_mode_lock), .init_state(b_init),
        .p_s0(b_p_s0), .p_s1(b_p_s1), .s0(b_s0), .s1(b_s1), .atf_s0(b_atf_s0),
        .atf_s1(b_atf_s1), .eq(b_eq), .s1_chg(b_s1_chg), .steps(b_steps),
        .steps_sat(b_steps_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step_a(input logic st0, input logic st1);
        a_start_s0 = st0;
        a_start_s1 = st1;
        @(posedge clk);
        #1;
        a_start_s0 = 1'b0;
        a_start_s1 = 1'b0;
    endtask

    task automatic step_b(input logic st0, input logic st1);
        b_start_s0 = st0;
        b_start_s1 = st1;
        @(posedge clk);
        #1;
        b_start_s0 = 1'b0;
        b_start_s1 = 1'b0;
    endtask

    task automatic nos_a(input logic [0:0] init);
        a_init      = init;
        a_reset_nos = 1'b1;
        @(posedge clk);
        #1;
        a_reset_nos = 1'b0;
    endtask

    task automatic nos_b(input logic [2:0] init);
        b_init      = init;
        b_reset_nos = 1'b1;
        @(posedge clk);
        #1;
        b_reset_nos = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({a_s0, a_s1, a_atf_s0, a_atf_s1, a_eq, a_s1_chg, a_steps_sat} !== 7'b0000100
            || a_steps !== 16'd0) begin
            errors++;
            $display("FAIL reset_a got s0=%b s1=%b eq=%b chg=%b steps=%0d sat=%b exp 0 0 1 0 0 0",
                     a_s0, a_s1, a_eq, a_s1_chg, a_steps, a_steps_sat);
        end
        checks++;
        if ({b_s0, b_s1, b_eq, b_s1_chg, b_steps, b_steps_sat} !== {3'd0, 3'd0, 1'b1, 1'b0, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_b got s0=%0d s1=%0d eq=%b chg=%b steps=%0d sat=%b exp 0 0 1 0 0 0",
                     b_s0, b_s1, b_eq, b_s1_chg, b_steps, b_steps_sat);
        end
    endtask

    task automatic test_ratio2();
        logic [0:0] p_tab [4];
        logic [0:0] e_tab [4];
        p_tab = '{1'b0, 1'b1, 1'b1, 1'b0};
        e_tab = '{1'b0, 1'b0, 1'b1, 1'b1};
        nos_a(1'b1);
        checks++;
        if ({a_s0, a_s1, a_eq, a_steps_sat} !== 4'b1110 || a_steps !== 16'd0) begin
            errors++;
            $display("FAIL nos_a got s0=%b s1=%b eq=%b steps=%0d exp 1 1 1 0", a_s0, a_s1, a_eq, a_steps);
        end
        for (int i = 0; i < 4; i++) begin
            a_p_s0 = p_tab[i];
            step_a(1'b1, 1'b0);
            checks++;
            if (a_s0 !== e_tab[i] || a_atf_s0 !== e_tab[i] || a_eq !== (e_tab[i] == 1'b1)) begin
                errors++;
                $display("FAIL ratio2_strobe%0d got s0=%b atf=%b eq=%b exp s0=%b", i + 1, a_s0, a_atf_s0, a_eq, e_tab[i]);
            end
        end
    endtask

    task automatic test_ratio3();
        logic [2:0] e_tab [6];
        e_tab = '{3'd1, 3'd1, 3'd1, 3'd4, 3'd4, 3'd4};
        b_mode_lock = 1'b0;
        nos_b(3'd0);
        for (int i = 0; i < 6; i++) begin
            b_p_s0 = 3'(i + 1);
            step_b(1'b1, 1'b0);
            checks++;
            if (b_s0 !== e_tab[i] || b_eq !== 1'b0 || b_s1 !== 3'd0) begin
                errors++;
                $display("FAIL ratio3_strobe%0d got s0=%0d eq=%b exp s0=%0d eq=0", i + 1, b_s0, b_eq, e_tab[i]);
            end
        end
    endtask

    task automatic test_simultaneous();
        nos_a(1'b1);
        a_p_s0 = 1'b1;
        a_p_s1 = 1'b1;
        step_a(1'b1, 1'b1);
        checks++;
        if ({a_s0, a_s1, a_eq, a_s1_chg} !== 4'b1110 || a_steps !== 16'd1) begin
            errors++;
            $display("FAIL simul_same got s0=%b s1=%b eq=%b chg=%b steps=%0d exp 1 1 1 0 1",
                     a_s0, a_s1, a_eq, a_s1_chg, a_steps);
        end
        a_p_s0 = 1'b0;
        a_p_s1 = 1'b0;
        step_a(1'b1, 1'b1);
        checks++;
        if ({a_s0, a_s1, a_atf_s1, a_eq, a_s1_chg} !== 5'b10001 || a_steps !== 16'd2) begin
            errors++;
            $display("FAIL simul_diff got s0=%b s1=%b eq=%b chg=%b steps=%0d exp 1 0 0 1 2",
                     a_s0, a_s1, a_eq, a_s1_chg, a_steps);
        end
        step_a(1'b0, 1'b0);
        checks++;
        if (a_s1_chg !== 1'b0 || a_steps !== 16'd2) begin
            errors++;
            $display("FAIL chg_pulse got chg=%b steps=%0d exp 0 2", a_s1_chg, a_steps);
        end
    endtask

    task automatic test_saturate();
        nos_b(3'd0);
        for (int i = 1; i <= 20; i++) begin
            b_p_s1 = 3'(i);
            step_b(1'b0, 1'b1);
            checks++;
            if (b_steps !== 4'((i > 15) ? 15 : i) || b_steps_sat !== (i >= 15) || b_s1 !== 3'(i)) begin
                errors++;
                $display("FAIL sat_step%0d got steps=%0d sat=%b s1=%0d exp steps=%0d sat=%b",
                         i, b_steps, b_steps_sat, b_s1, (i > 15) ? 15 : i, (i >= 15));
            end
        end
    endtask

    task automatic test_lock();
        logic       l_tab [8];
        logic [2:0] p_tab [8];
        logic [2:0] e_tab [8];
        l_tab = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        p_tab = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1};
        e_tab = '{3'd1, 3'd1, 3'd3, 3'd4, 3'd5, 3'd5, 3'd7, 3'd7};
        nos_b(3'd0);
        for (int i = 0; i < 8; i++) begin
            b_mode_lock = l_tab[i];
            b_p_s0      = p_tab[i];
            step_b(1'b1, 1'b0);
            checks++;
            if (b_s0 !== e_tab[i]) begin
                errors++;
                $display("FAIL lock_strobe%0d got s0=%0d exp %0d", i + 1, b_s0, e_tab[i]);
            end
        end
        b_mode_lock = 1'b0;
    endtask

    task automatic test_async_reset();
        nos_b(3'd7);
        checks++;
        if (b_s0 !== 3'd7 || b_s1 !== 3'd7 || b_eq !== 1'b1) begin
            errors++;
            $display("FAIL preload7 got s0=%0d s1=%0d eq=%b exp 7 7 1", b_s0, b_s1, b_eq);
        end
        b_p_s1 = 3'd2;
        step_b(1'b0, 1'b1);
        b_p_s1 = 3'd7;
        step_b(1'b0, 1'b1);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({b_s0, b_s1, b_atf_s0, b_atf_s1, b_eq, b_s1_chg, b_steps, b_steps_sat}
                !== {3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL async_rst_b got s0=%0d s1=%0d eq=%b chg=%b steps=%0d sat=%b exp 0 0 1 0 0 0",
                     b_s0, b_s1, b_eq, b_s1_chg, b_steps, b_steps_sat);
        end
        checks++;
        if ({a_s0, a_s1, a_eq, a_s1_chg, a_steps_sat} !== 5'b00100 || a_steps !== 16'd0) begin
            errors++;
            $display("FAIL async_rst_a got s0=%b s1=%b eq=%b steps=%0d exp 0 0 1 0", a_s0, a_s1, a_eq, a_steps);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_post_reset_phase();
        logic [2:0] e_tab [3];
        e_tab = '{3'd0, 3'd0, 3'd3};
        a_p_s0 = 1'b1;
        step_a(1'b1, 1'b0);
        checks++;
        if (a_s0 !== 1'b0) begin
            errors++;
            $display("FAIL post_rst_a1 got s0=%b exp 0", a_s0);
        end
        step_a(1'b1, 1'b0);
        checks++;
        if (a_s0 !== 1'b1) begin
            errors++;
            $display("FAIL post_rst_a2 got s0=%b exp 1", a_s0);
        end
        b_p_s0 = 3'd3;
        for (int i = 0; i < 3; i++) begin
            step_b(1'b1, 1'b0);
            checks++;
            if (b_s0 !== e_tab[i]) begin
                errors++;
                $display("FAIL post_rst_b%0d got s0=%0d exp %0d", i + 1, b_s0, e_tab[i]);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        a_reset_nos = 1'b0; a_start_s0 = 1'b0; a_start_s1 = 1'b0; a_mode_lock = 1'b0;
        a_init = 1'b0; a_p_s0 = 1'b0; a_p_s1 = 1'b0;
        b_reset_nos = 1'b0; b_start_s0 = 1'b0; b_start_s1 = 1'b0; b_mode_lock = 1'b0;
        b_init = 3'd0; b_p_s0 = 3'd0; b_p_s1 = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        test_ratio2();
        test_ratio3();
        test_simultaneous();
        test_saturate();
        test_lock();
        test_async_reset();
        test_post_reset_phase();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gnr_node_floyd.md
GNR_NODE_FLOYD -- requirements
Module: gnr_node_floyd

Interface
REQ-001 Parameter WIDTH, default 1, bits per node state (multi-valued GNR nodes).
REQ-002 Parameter RATIO, default 2, start_s0 pulses per s0 update in Floyd mode; legal range is 1..255.
REQ-003 Parameter CNT_W, default 16, width of the step counter.
REQ-004 Port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Port rst  in  1  reset, asynchronous assert, active-low; synchronous deassert is provided externally.
REQ-006 Port reset_nos  in  1  synchronous re-initialisation of the node to init_state.
REQ-007 Port start_s0  in  1  step strobe for the slow (tortoise) copy.
REQ-008 Port start_s1  in  1  step strobe for the fast (hare) copy.
REQ-009 Port mode_lock  in  1  0 = Floyd mode (s0 updates once per RATIO strobes); 1 = lockstep (s0 updates on every strobe).
REQ-010 Port init_state  in  WIDTH  initial state loaded by reset_nos.
REQ-011 Port p_s0, p_s1  in  WIDTH each  next-state function values for the s0 and s1 copies.
REQ-012 Port s0, s1  out  WIDTH each  registered node state copies.
REQ-013 Port atf_s0, atf_s1  out  WIDTH each  fan-out aliases equal to s0 and s1.
REQ-014 Port eq  out  1  registered flag, s0 == s1 after the last edge.
REQ-015 Port s1_chg  out  1  one-cycle pulse: the last s1 update changed its value.
REQ-016 Port steps  out  CNT_W  count of s1 updates since the last reset_nos, saturating.
REQ-017 Port steps_sat  out  1  steps has reached its all-ones value.

Function
REQ-018 The block SHALL apply priority rst > reset_nos > start strobes.
REQ-019 On reset_nos, the block SHALL:
- load s0 and s1 with init_state;
- set phase to RATIO-1;
- clear steps, steps_sat and s1_chg;
- set eq to 1.
REQ-020 Floyd mode, start_s0 with phase == RATIO-1: s0 <= p_s0 and phase <= 0.
REQ-021 Floyd mode, start_s0 with phase < RATIO-1: phase <= phase+1 and s0 holds.
REQ-022 The first start_s0 after reset_nos SHALL update s0, in every mode.
REQ-023 Lockstep mode, start_s0: s0 <= p_s0 with phase unchanged; on return to Floyd mode, phase resumes from its held value.
REQ-024 For RATIO = 1, Floyd mode SHALL behave identically to lockstep.
REQ-025 On start_s1: s1 <= p_s1, steps increments, and s1_chg <= (p_s1 != s1); s1_chg is 0 in every other cycle.
REQ-026 steps SHALL saturate at all-ones, with no wrap; steps_sat SHALL be 1 exactly when steps is all-ones.
REQ-027 eq SHALL be computed from the next-state values of s0 and s1, so it is valid in the same cycle as the updated registers.
REQ-028 start_s0 and start_s1 in the same cycle SHALL be processed independently; neither blocks the other.
REQ-029 Latency from strobe to updated s0/s1/eq/steps SHALL be 1 clock.
REQ-030 p_s0 and p_s1 SHALL be sampled only on their respective strobe cycles.

Reset
REQ-031 While rst = 0, the block SHALL asynchronously clear s0, s1, phase, steps, steps_sat and s1_chg, and set eq = 1.
REQ-032 rst asserted mid-step SHALL discard any pending update; the first post-reset start_s0 SHALL be a non-updating phase step only, since phase = 0.
REQ-033 No output SHALL be X after rst, for any parameter set.

Structure
REQ-034 A shared package gnr_pkg SHALL hold the MODE_FLOYD/MODE_LOCK constants, the RATIO range check and the phase-width function clog2(RATIO).
REQ-035 The phase logic SHALL be one sub-module gnr_phase_div (parameter RATIO; ports: clk, rst, load, en, lock, fire).
REQ-036 Parameter checks SHALL be elaboration-time assertions.

Verification
REQ-037 WIDTH=1, RATIO=2: reset_nos with init=1, p_s0=0, then 4 start_s0 -> s0 goes 1→0 after strobe 1, holds through 2, then updates after 3 (matches the 2-phase behaviour).
REQ-038 WIDTH=3, RATIO=3, Floyd mode, p_s0=5: 6 start_s0 -> s0 updates on strobes 1 and 4 only.
REQ-039 Simultaneous start_s0 and start_s1 with p_s0 = p_s1 = init -> eq stays 1, s1_chg = 0, steps = 1.
REQ-040 CNT_W=4: 20 start_s1 -> steps = 15, steps_sat = 1, no wrap.
REQ-041 rst pulled low mid-run while s0 = s1 = 7 -> all outputs 0, eq = 1 immediately, without waiting for a clock edge.
REQ-042 mode_lock = 1 for 3 start_s0, then 0 -> 3 updates in lock mode, then Floyd updates resume from the held phase.
